// File: rtl/reduce_gate_sweep.sv
// ---------------------------------------------------------------------------
// reduce_gate_sweep
//
// Purpose:
//   N-input reduction gate (AND/OR/XOR/XNOR/NAND/NOR/BUF/NOT) combined with an
//   exhaustive sweeper. A start request walks every one of the 2^N input
//   vectors in ascending order and holds each for HOLD cycles. The gate output
//   is registered every sweep cycle, and the last hold cycle of each vector
//   writes that vector's result into a truth-table register. A one-cycle done
//   pulse marks the end of the sweep. The block serves as the on-chip
//   self-check for the gate-level cells and as a stimulus/response source for
//   the gate benches.
//
// Parameters:
//   N     gate input count, legal 2..8 (truth table is 2^N bits)
//   HOLD  cycles each vector is held, legal 1..255
//
// Ports:
//   clk       in   1     single clock, all state on the rising edge
//   rst_n     in   1     synchronous reset, active-low
//   start     in   1     sweep request, only looked at while idle
//   op        in   3     000 AND, 001 OR, 010 XOR, 011 XNOR,
//                        100 NAND, 101 NOR, 110 BUF(vec[0]), 111 NOT(vec[0])
//   vec       out  N     input vector currently driven to the gate
//   y         out  1     registered gate output, f(vec) of the previous cycle
//   busy      out  1     high while the sweep is running
//   done      out  1     one-cycle pulse when the sweep completes
//   tt        out  2^N   truth table, tt[i] = f(i)
//   tt_valid  out  1     tt complete; held until the next accepted start
//
// Optional feature (macro TT_CHECK_EN):
//   exp_tt    in   2^N   expected truth table
//   mismatch  out  1     set on entry to DONE when the finished table differs
//                        from exp_tt; cleared at reset and on an accepted start
//   With TT_CHECK_EN undefined these two ports and their logic do not exist.
// ---------------------------------------------------------------------------
module reduce_gate_sweep #(
    parameter int N    = 4,
    parameter int HOLD = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    output logic [N-1:0]        vec,
    output logic                y,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   tt,
    output logic                tt_valid
`ifdef TT_CHECK_EN
    ,
    input  logic [(1<<N)-1:0]   exp_tt,
    output logic                mismatch
`endif
);

    localparam int             TT_W      = 1 << N;
    localparam logic [N-1:0]   VEC_LAST  = {N{1'b1}};
    localparam logic [N-1:0]   VEC_ONE   = {{(N-1){1'b0}}, 1'b1};
    // Hold counter is sized for the largest legal HOLD (255).
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [7:0]        hold_cnt;
    logic [2:0]        op_q;
    logic              f_cur;
    logic [TT_W-1:0]   tt_final;

    // Reduction gate. The reducing ops consume all N bits of the vector;
    // BUF and NOT look only at bit 0.
    function automatic logic gate_eval(input logic [2:0] sel, input logic [N-1:0] v);
        logic r;
        case (sel)
            3'b000:  r = &v;
            3'b001:  r = |v;
            3'b010:  r = ^v;
            3'b011:  r = ~^v;
            3'b100:  r = ~&v;
            3'b101:  r = ~|v;
            3'b110:  r = v[0];
            default: r = ~v[0];
        endcase
        return r;
    endfunction

    // Gate result for the vector on the bus now, plus the truth table as it
    // will look once that result is written. The completion check compares
    // against this next-table so the final bit is included.
    always_comb begin
        f_cur         = gate_eval(op_q, vec);
        tt_final      = tt;
        tt_final[vec] = f_cur;
    end

    // Sweep controller. All outputs are registered here. The op is latched
    // when a start is accepted so changes on the op input mid-sweep have no
    // effect. A start seen in RUN or DONE is dropped, not queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            vec      <= '0;
            y        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= '0;
            tt_valid <= 1'b0;
            hold_cnt <= '0;
            op_q     <= 3'b000;
`ifdef TT_CHECK_EN
            mismatch <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        op_q     <= op;
                        vec      <= '0;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        tt       <= '0;
                        tt_valid <= 1'b0;
`ifdef TT_CHECK_EN
                        mismatch <= 1'b0;
`endif
                    end
                end

                S_RUN: begin
                    // y trails vec by exactly one cycle while sweeping.
                    y <= f_cur;
                    if (hold_cnt == HOLD_LAST) begin
                        // Last hold cycle of this vector: commit its result.
                        hold_cnt <= '0;
                        tt       <= tt_final;
                        if (vec != VEC_LAST) begin
                            vec <= vec + VEC_ONE;
                        end else begin
                            // Final vector stays on the bus until the next start.
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tt_valid <= 1'b1;
`ifdef TT_CHECK_EN
                            mismatch <= (tt_final != exp_tt);
`endif
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_gate_sweep.sv
// ---------------------------------------------------------------------------
// tb_reduce_gate_sweep
//
// Scoreboard bench for reduce_gate_sweep. Three instances share clk/rst_n:
//   a : N=4, HOLD=1   (main function, op latching, reset abort, re-trigger)
//   b : N=4, HOLD=3   (vector hold time and y lag)
//   c : N=2, HOLD=1   (small table)
// Issuing a sweep pushes its hand-computed truth table and busy length into
// that instance's queue; per-instance monitors on the falling edge pop and
// compare whenever done pulses, and also track vec stepping and y lag.
// With TT_CHECK_EN defined the optional ports are connected and checked.
// ---------------------------------------------------------------------------
module tb_reduce_gate_sweep;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] tt;
        int          cycles;
        logic        mm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, start_b, start_c;
    logic [2:0]  op_a, op_b, op_c;
    logic [3:0]  vec_a, vec_b;
    logic [1:0]  vec_c;
    logic        y_a, y_b, y_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] tt_a, tt_b;
    logic [3:0]  tt_c;
    logic        tt_valid_a, tt_valid_b, tt_valid_c;
`ifdef TT_CHECK_EN
    logic [15:0] exp_tt_a, exp_tt_b;
    logic [3:0]  exp_tt_c;
    logic        mismatch_a, mismatch_b, mismatch_c;
`endif

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t exp_c[$];

    int checks = 0;
    int errors = 0;

    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
    logic       prev_busy_a = 1'b0, prev_busy_b = 1'b0, prev_busy_c = 1'b0;
    logic [3:0] prev_vec_a = '0, prev_vec_b = '0;
    logic [1:0] prev_vec_c = '0;
    exp_t       ea, eb, ec;

    always #5 clk = ~clk;

    reduce_gate_sweep #(.N(4), .HOLD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a),
        .vec(vec_a), .y(y_a), .busy(busy_a), .done(done_a),
        .tt(tt_a), .tt_valid(tt_valid_a)
`ifdef TT_CHECK_EN
        , .exp_tt(exp_tt_a), .mismatch(mismatch_a)
`endif
    );

    reduce_gate_sweep #(.N(4), .HOLD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b),
        .vec(vec_b), .y(y_b), .busy(busy_b), .done(done_b),
        .tt(tt_b), .tt_valid(tt_valid_b)
`ifdef TT_CHECK_EN
        , .exp_tt(exp_tt_b), .mismatch(mismatch_b)
`endif
    );

    reduce_gate_sweep #(.N(2), .HOLD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op(op_c),
        .vec(vec_c), .y(y_c), .busy(busy_c), .done(done_c),
        .tt(tt_c), .tt_valid(tt_valid_c)
`ifdef TT_CHECK_EN
        , .exp_tt(exp_tt_c), .mismatch(mismatch_c)
`endif
    );

    // Reference gate built from a ones count rather than reduction operators.
    function automatic logic ref_gate(input logic [2:0] o, input logic [7:0] v, input int w);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += int'(v[i]);
        case (o)
            3'd0:    return (ones == w);
            3'd1:    return (ones > 0);
            3'd2:    return ((ones % 2) == 1);
            3'd3:    return ((ones % 2) == 0);
            3'd4:    return (ones != w);
            3'd5:    return (ones == 0);
            3'd6:    return v[0];
            default: return !v[0];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_vec",      32'(vec_a),      32'd0);
        checkOutput("rst_y",        32'(y_a),        32'd0);
        checkOutput("rst_busy",     32'(busy_a),     32'd0);
        checkOutput("rst_done",     32'(done_a),     32'd0);
        checkOutput("rst_tt",       32'(tt_a),       32'd0);
        checkOutput("rst_tt_valid", 32'(tt_valid_a), 32'd0);
    endtask

    // Requests a sweep on one instance and returns just after the edge that
    // raised busy (start is released there).
    task automatic applyStimulus(input int which, input logic [2:0] o, input logic [15:0] res,
                                 input int cycles, input logic mm, input bit do_push);
        exp_t e;
        logic started;
        e.op = o; e.tt = res; e.cycles = cycles; e.mm = mm;
        @(negedge clk);
        if (do_push) begin
            case (which)
                0:       exp_a.push_back(e);
                1:       exp_b.push_back(e);
                default: exp_c.push_back(e);
            endcase
        end
        case (which)
            0: begin
                op_a = o; start_a = 1'b1;
`ifdef TT_CHECK_EN
                exp_tt_a = mm ? (res ^ 16'h0001) : res;
`endif
            end
            1: begin
                op_b = o; start_b = 1'b1;
`ifdef TT_CHECK_EN
                exp_tt_b = mm ? (res ^ 16'h0001) : res;
`endif
            end
            default: begin
                op_c = o; start_c = 1'b1;
`ifdef TT_CHECK_EN
                exp_tt_c = mm ? (res[3:0] ^ 4'h1) : res[3:0];
`endif
            end
        endcase
        started = 1'b0;
        for (int i = 0; i < 8 && !started; i++) begin
            @(posedge clk); #1;
            started = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
        end
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic waitDone(input int which, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL done_timeout_%0d actual=0 required=1", which);
        end
    endtask

    // Monitor a: y lag, vec stepping and scoreboard pop on done.
    always @(negedge clk) begin
        if (prev_busy_a && (busy_a || done_a) && exp_a.size() > 0)
            checkOutput("y_lag_a", 32'(y_a), 32'(ref_gate(exp_a[0].op, 8'(prev_vec_a), 4)));
        if (busy_a) begin
            checkOutput("vec_step_a", 32'(vec_a), 32'(cnt_a));
            cnt_a++;
        end
        if (done_a) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_done_a actual=1 required=0");
            end else begin
                ea = exp_a.pop_front();
                checkOutput("tt_a",         32'(tt_a),       32'(ea.tt));
                checkOutput("tt_valid_a",   32'(tt_valid_a), 32'd1);
                checkOutput("busy_len_a",   32'(cnt_a),      32'(ea.cycles));
                checkOutput("busy_low_a",   32'(busy_a),     32'd0);
`ifdef TT_CHECK_EN
                checkOutput("mismatch_a",   32'(mismatch_a), 32'(ea.mm));
`endif
            end
        end
        if (!busy_a) cnt_a = 0;
        prev_busy_a = busy_a;
        prev_vec_a  = vec_a;
    end

    // Monitor b: each vector must persist for three cycles.
    always @(negedge clk) begin
        if (prev_busy_b && (busy_b || done_b) && exp_b.size() > 0)
            checkOutput("y_lag_b", 32'(y_b), 32'(ref_gate(exp_b[0].op, 8'(prev_vec_b), 4)));
        if (busy_b) begin
            checkOutput("vec_hold_b", 32'(vec_b), 32'(cnt_b / 3));
            cnt_b++;
        end
        if (done_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_done_b actual=1 required=0");
            end else begin
                eb = exp_b.pop_front();
                checkOutput("tt_b",         32'(tt_b),       32'(eb.tt));
                checkOutput("tt_valid_b",   32'(tt_valid_b), 32'd1);
                checkOutput("busy_len_b",   32'(cnt_b),      32'(eb.cycles));
`ifdef TT_CHECK_EN
                checkOutput("mismatch_b",   32'(mismatch_b), 32'(eb.mm));
`endif
            end
        end
        if (!busy_b) cnt_b = 0;
        prev_busy_b = busy_b;
        prev_vec_b  = vec_b;
    end

    // Monitor c: two-input build.
    always @(negedge clk) begin
        if (prev_busy_c && (busy_c || done_c) && exp_c.size() > 0)
            checkOutput("y_lag_c", 32'(y_c), 32'(ref_gate(exp_c[0].op, 8'(prev_vec_c), 2)));
        if (busy_c) begin
            checkOutput("vec_step_c", 32'(vec_c), 32'(cnt_c));
            cnt_c++;
        end
        if (done_c) begin
            if (exp_c.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpected_done_c actual=1 required=0");
            end else begin
                ec = exp_c.pop_front();
                checkOutput("tt_c",         32'(tt_c),       32'(ec.tt));
                checkOutput("tt_valid_c",   32'(tt_valid_c), 32'd1);
                checkOutput("busy_len_c",   32'(cnt_c),      32'(ec.cycles));
`ifdef TT_CHECK_EN
                checkOutput("mismatch_c",   32'(mismatch_c), 32'(ec.mm));
`endif
            end
        end
        if (!busy_c) cnt_c = 0;
        prev_busy_c = busy_c;
        prev_vec_c  = vec_c;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        op_a = 3'd0; op_b = 3'd0; op_c = 3'd0;
`ifdef TT_CHECK_EN
        exp_tt_a = '0; exp_tt_b = '0; exp_tt_c = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        // XNOR sweep; a start pulse with a new op mid-run must be ignored.
        applyStimulus(0, 3'b011, 16'h9669, 16, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start_a = 1'b1; op_a = 3'b000;
        @(negedge clk);
        start_a = 1'b0;
        waitDone(0, 100);

        // Results and final vector persist while idle.
        repeat (5) @(negedge clk);
        checkOutput("tt_hold",       32'(tt_a),       32'h9669);
        checkOutput("tt_valid_hold", 32'(tt_valid_a), 32'd1);
        checkOutput("vec_hold",      32'(vec_a),      32'hF);
        checkOutput("busy_idle",     32'(busy_a),     32'd0);

        // tt_valid and tt clear on the edge that accepts the next start.
        applyStimulus(0, 3'b101, 16'h0001, 16, 1'b0, 1'b1);
        checkOutput("tt_valid_drop", 32'(tt_valid_a), 32'd0);
        checkOutput("tt_clear",      32'(tt_a),       32'd0);
        checkOutput("vec_restart",   32'(vec_a),      32'd0);
        waitDone(0, 100);

        applyStimulus(0, 3'b001, 16'hFFFE, 16, 1'b0, 1'b1); waitDone(0, 100);
        applyStimulus(0, 3'b000, 16'h8000, 16, 1'b0, 1'b1); waitDone(0, 100);
        applyStimulus(0, 3'b100, 16'h7FFF, 16, 1'b0, 1'b1); waitDone(0, 100);
        applyStimulus(0, 3'b111, 16'h5555, 16, 1'b0, 1'b1); waitDone(0, 100);
        applyStimulus(0, 3'b110, 16'hAAAA, 16, 1'b0, 1'b1); waitDone(0, 100);
        applyStimulus(0, 3'b010, 16'h6996, 16, 1'b0, 1'b1); waitDone(0, 100);
        // Expected table off by one bit: mismatch when checking is built in.
        applyStimulus(0, 3'b011, 16'h9669, 16, 1'b1, 1'b1); waitDone(0, 100);

        // HOLD=3 instance.
        applyStimulus(1, 3'b010, 16'h6996, 48, 1'b0, 1'b1); waitDone(1, 200);

        // N=2 instance.
        applyStimulus(2, 3'b011, 16'h0009, 4, 1'b0, 1'b1); waitDone(2, 50);

        // Reset at vec=7 aborts the sweep without a done pulse.
        applyStimulus(0, 3'b000, 16'h8000, 16, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vec_a == 4'd7) break;
        end
        checkOutput("reach_vec7", 32'(vec_a), 32'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("no_done_after_abort", 32'(tt_valid_a), 32'd0);
        applyStimulus(0, 3'b001, 16'hFFFE, 16, 1'b0, 1'b1); waitDone(0, 100);

        // Start held high re-triggers a second sweep from IDLE.
        @(negedge clk);
        begin
            exp_t e;
            e.op = 3'b111; e.tt = 16'h5555; e.cycles = 16; e.mm = 1'b0;
            exp_a.push_back(e);
            exp_a.push_back(e);
        end
`ifdef TT_CHECK_EN
        exp_tt_a = 16'h5555;
`endif
        op_a = 3'b111; start_a = 1'b1;
        waitDone(0, 100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy_a) break;
        end
        checkOutput("retrigger_busy", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        waitDone(0, 100);

        repeat (5) @(negedge clk);
        checkOutput("queue_a_drained", 32'(exp_a.size()), 32'd0);
        checkOutput("queue_b_drained", 32'(exp_b.size()), 32'd0);
        checkOutput("queue_c_drained", 32'(exp_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
